// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Front end of the pipeline. It owns the PC, drives the instruction memory
// address and captures the word that comes back in the same cycle into the
// IF/ID pipeline register. Redirects (branches), stalls, flushes and a
// terminal halt are resolved here with a fixed priority.
//
// Ports
//   Clk               rising-edge clock
//   Rst               synchronous, active-high reset
//   Instruction[31:0] word from instruction memory for Address (same cycle)
//   Stall             hold PC and IF/ID
//   Flush             load a bubble into IF/ID
//   BranchTaken       redirect PC to BranchTarget (word aligned)
//   BranchTarget      redirect byte address
//   Halt              stop fetching until the next reset
//   Address[31:0]     instruction memory byte address (== PC)
//   IfId_Instruction  registered fetched word
//   IfId_PCPlus4      registered PC+4 of the fetched word
//   IfId_Valid        IF/ID holds a real instruction
//   FetchCount        number of valid words captured into IF/ID
//   Halted            unit is in the HALTED state
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] Instruction,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Halt,
  output logic [31:0] Address,
  output logic [31:0] IfId_Instruction,
  output logic [31:0] IfId_PCPlus4,
  output logic        IfId_Valid,
  output logic [31:0] FetchCount,
  output logic        Halted
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  // IF/ID pipeline register contents
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  localparam ifid_t BUBBLE = '{instr: 32'h0, pc_plus4: 32'h0, valid: 1'b0};

  // PC is always word aligned, even if the reset vector is not.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  ifid_t       ifid_q, ifid_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic [31:0] pc_plus4;
  logic        tgt_unused;

  // Branch targets are forced to a word boundary; the low bits are dropped.
  assign tgt_unused = ^BranchTarget[1:0];

  // Wraps silently at the top of the address space.
  assign pc_plus4 = pc_q + 32'd4;

  // -------------------------------------------------------------------------
  // Next-state / next-contents
  // -------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ifid_d        = ifid_q;
    fetch_count_d = fetch_count_q;

    unique case (state_q)
      RUN: begin
        if (Halt) begin
          // Halt outranks everything: freeze PC, drain IF/ID.
          state_d = HALTED;
          ifid_d  = BUBBLE;
        end else if (BranchTaken) begin
          // Redirect wins over a stall; the wrong-path fetch is discarded.
          pc_d   = {BranchTarget[31:2], 2'b00};
          ifid_d = BUBBLE;
        end else if (Stall) begin
          // PC holds; IF/ID holds unless squashed by a concurrent flush.
          if (Flush) ifid_d = BUBBLE;
        end else if (Flush) begin
          // Fetch still advances, but the captured word is squashed.
          pc_d   = pc_plus4;
          ifid_d = BUBBLE;
        end else begin
          pc_d          = pc_plus4;
          ifid_d.instr    = Instruction;
          ifid_d.pc_plus4 = pc_plus4;
          ifid_d.valid    = 1'b1;
          fetch_count_d = fetch_count_q + 32'd1;
        end
      end
      HALTED: begin
        // Only reset leaves this state; all control inputs are ignored.
        state_d = HALTED;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC_ALIGNED;
      ifid_q        <= BUBBLE;
      fetch_count_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ifid_q        <= ifid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign Address          = pc_q;
  assign IfId_Instruction = ifid_q.instr;
  assign IfId_PCPlus4     = ifid_q.pc_plus4;
  assign IfId_Valid       = ifid_q.valid;
  assign FetchCount       = fetch_count_q;
  assign Halted           = (state_q == HALTED);

endmodule
